// File: rtl/shifter_pkg.sv
// ============================================================================
// Module  : shifter_pkg
// Purpose : Shared definitions for the serial shift/rotate unit: the datapath
//           op encoding, the sequencer state encoding, the per-cycle step
//           width and the legality check for the STEP_BITS parameter.
// Macros  : SERIAL_SHIFTER_ROTATE_EN is used by the files that import this
//           package. It is not referenced here.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package shifter_pkg;

  // Op encoding shared with the combinational datapath rotator.
  localparam logic [1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [1:0] SHIFT_OP_ROR = 2'b01;
  localparam logic [1:0] SHIFT_OP_SRL = 2'b10;
  localparam logic [1:0] SHIFT_OP_SRA = 2'b11;

  // Width of the per-cycle step count k. It holds 0..8, which covers the
  // largest legal STEP_BITS.
  localparam int K_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic bit step_bits_legal(input int s);
    return (s == 1) || (s == 2) || (s == 4) || (s == 8);
  endfunction

endpackage : shifter_pkg

`default_nettype wire

// File: rtl/serial_shifter_shift_step.sv
// ============================================================================
// Module  : shift_step
// Purpose : Combinational single step of the serial shifter. Shifts or
//           rotates a 32-bit value by k (0..STEP_BITS) under the datapath op.
// Ports   : data_i [31:0]   value before this step
//           k_i    [K_W-1:0] positions to move this step
//           op_i   [1:0]    00 SLL, 01 ROR, 10 SRL, 11 SRA
//           data_o [31:0]   value after this step
// Macros  : SERIAL_SHIFTER_ROTATE_EN
//             defined   : op 01 rotates right.
//             undefined : op 01 yields zero and no rotate leg is built.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_step
  import shifter_pkg::*;
(
  input  logic [31:0]    data_i,
  input  logic [K_W-1:0] k_i,
  input  logic [1:0]     op_i,
  output logic [31:0]    data_o
);

  always_comb begin
    data_o = '0;
    case (op_i)
      SHIFT_OP_SLL: data_o = data_i << k_i;
      SHIFT_OP_SRL: data_o = data_i >> k_i;
      // Bit 31 is refilled from itself, so the sign survives every step.
      SHIFT_OP_SRA: data_o = $unsigned($signed(data_i) >>> k_i);
      SHIFT_OP_ROR: begin
`ifdef SERIAL_SHIFTER_ROTATE_EN
        // For k=0 the left shift is by 32, which gives zero and leaves
        // data_i unchanged.
        data_o = (data_i >> k_i) | (data_i << (6'd32 - {2'b00, k_i}));
`else
        data_o = '0;
`endif
      end
      default: data_o = '0;
    endcase
  end

endmodule : shift_step

`default_nettype wire

// File: rtl/serial_shifter.sv
// ============================================================================
// Module  : serial_shifter
// Purpose : Iterative 32-bit shift/rotate unit. It moves STEP_BITS positions
//           per cycle and uses a start/busy/done handshake. The result is
//           held until the next completion or reset.
// Params  : STEP_BITS  bits shifted per cycle (1, 2, 4 or 8)
// Ports   : clk          rising-edge clock
//           rst          synchronous active-high reset
//           start        request, accepted only in IDLE or DONE
//           shift_in     operand, captured on accept
//           shift_amt    shift count 0..31, captured on accept
//           shift_op     00 SLL, 01 ROR, 10 SRL, 11 SRA, captured on accept
//           busy         high while in SHIFT
//           done         one-cycle completion pulse
//           shift_out    result register
// Macros  : SERIAL_SHIFTER_ROTATE_EN
//             defined   : op 01 rotates right.
//             undefined : op 01 handshakes normally and returns zero.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_shifter
  import shifter_pkg::*;
#(
  parameter int STEP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] shift_in,
  input  logic [4:0]  shift_amt,
  input  logic [1:0]  shift_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] shift_out
);

  if (!step_bits_legal(STEP_BITS)) begin : g_bad_step_bits
    $fatal(1, "serial_shifter: STEP_BITS must be 1, 2, 4 or 8");
  end

  state_t         state_q;
  logic [31:0]    work_q;
  logic [31:0]    shift_out_q;
  logic [4:0]     rem_q;
  logic [4:0]     rem_d;
  logic [1:0]     op_q;
  logic           busy_q;
  logic           done_q;
  logic [K_W-1:0] k;
  logic [31:0]    step_res;
  logic [31:0]    amt0_res;

  // k = min(STEP_BITS, remaining). The final step may be partial.
  always_comb begin
    k = K_W'(STEP_BITS);
    if (rem_q < 5'(STEP_BITS)) begin
      k = K_W'(rem_q);
    end
    rem_d = rem_q - 5'(k);
  end

  shift_step u_shift_step (
    .data_i (work_q),
    .k_i    (k),
    .op_i   (op_q),
    .data_o (step_res)
  );

  // A zero-count request completes on the accept edge and never uses the
  // step logic. It still has to follow the zero result of the disabled
  // rotate op.
`ifdef SERIAL_SHIFTER_ROTATE_EN
  assign amt0_res = shift_in;
`else
  assign amt0_res = (shift_op == SHIFT_OP_ROR) ? 32'h0 : shift_in;
`endif

  // Sequencer. busy_q and done_q are loaded with the decode of the next
  // state, so they always equal (state == SHIFT) and (state == DONE).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      rem_q       <= '0;
      op_q        <= SHIFT_OP_SLL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_out_q <= '0;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          // start is ignored here. Only the step registers advance.
          work_q <= step_res;
          rem_q  <= rem_d;
          if (rem_d == 5'd0) begin
            shift_out_q <= step_res;
            state_q     <= ST_DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept. Accepting in DONE gives
          // back-to-back operation with no bubble.
          if (start) begin
            work_q <= shift_in;
            rem_q  <= shift_amt;
            op_q   <= shift_op;
            if (shift_amt == 5'd0) begin
              shift_out_q <= amt0_res;
              state_q     <= ST_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_out = shift_out_q;

endmodule : serial_shifter

`default_nettype wire

// File: tb/tb_serial_shifter.sv
// ============================================================================
// Module  : tb_serial_shifter
// Purpose : Self-checking bench for serial_shifter. Two instances are built,
//           one with STEP_BITS=1 and one with STEP_BITS=4. Each instance has
//           its own stimulus signals. Expected results and latencies come from
//           a behavioural model that uses whole-amount shifts.
// Macros  : SERIAL_SHIFTER_ROTATE_EN selects the expected rotate behaviour.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [31:0] sin   [2];
  logic [4:0]  samt  [2];
  logic [1:0]  sop   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] sout  [2];
  logic [31:0] last_out [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_shifter #(.STEP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .shift_in(sin[0]),
    .shift_amt(samt[0]), .shift_op(sop[0]), .busy(busy[0]), .done(done[0]),
    .shift_out(sout[0])
  );

  serial_shifter #(.STEP_BITS(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .shift_in(sin[1]),
    .shift_amt(samt[1]), .shift_op(sop[1]), .busy(busy[1]), .done(done[1]),
    .shift_out(sout[1])
  );

  // ---------------- reference model ----------------
  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] exp_result(input logic [31:0] in,
                                             input logic [4:0] amt,
                                             input logic [1:0] op);
    logic [63:0] dbl;
    int a;
    a = int'(amt);
    case (op)
      2'b00: return in << a;
      2'b10: return in >> a;
      2'b11: return 32'($signed(in) >>> a);
      default: begin
`ifdef SERIAL_SHIFTER_ROTATE_EN
        dbl = {in, in} >> a;
        return dbl[31:0];
`else
        dbl = 64'h0;
        return dbl[31:0];
`endif
      end
    endcase
  endfunction

  function automatic int exp_lat(input int d, input logic [4:0] amt);
    return (int'(amt) + step_of(d) - 1) / step_of(d);
  endfunction

  // ---------------- stimulus helpers ----------------
  // Call at a negedge. On return the accept edge has passed, the bench is at
  // the next negedge, and the operands have been replaced with junk.
  task automatic issue(input int d, input logic [31:0] in,
                       input logic [4:0] amt, input logic [1:0] op);
    start[d] = 1'b1; sin[d] = in; samt[d] = amt; sop[d] = op;
    @(negedge clk);
    start[d] = 1'b0;
    sin[d]   = $urandom;
    samt[d]  = 5'($urandom);
    sop[d]   = 2'($urandom);
  endtask

  // Checks busy, done and shift_out for every cycle up to and including the
  // done cycle. On return the bench is still inside the done cycle.
  task automatic expect_op(input int d, input logic [31:0] in,
                           input logic [4:0] amt, input logic [1:0] op,
                           input bit poke);
    int n;
    logic [31:0] res;
    n   = exp_lat(d, amt);
    res = exp_result(in, amt, op);
    for (int c = 1; c <= n + 1; c++) begin
      if (poke && c == 2) begin
        start[d] = 1'b1; sin[d] = $urandom; samt[d] = 5'd1; sop[d] = 2'($urandom);
      end
      if (poke && c == 3) start[d] = 1'b0;
      n_checks++;
      if (busy[d] !== (c <= n)) $display("FAIL busy dut%0d cyc%0d: got %b want %b", d, c, busy[d], (c <= n));
      else n_pass++;
      n_checks++;
      if (done[d] !== (c == n + 1)) $display("FAIL done dut%0d cyc%0d: got %b want %b", d, c, done[d], (c == n + 1));
      else n_pass++;
      n_checks++;
      if (sout[d] !== ((c == n + 1) ? res : last_out[d]))
        $display("FAIL shift_out dut%0d cyc%0d in=%h amt=%0d op=%0d: got %h want %h",
                 d, c, in, amt, op, sout[d], (c == n + 1) ? res : last_out[d]);
      else n_pass++;
      if (c <= n) @(negedge clk);
    end
    last_out[d] = res;
  endtask

  task automatic idle_check(input int d);
    @(negedge clk);
    n_checks++;
    if (busy[d] !== 1'b0 || done[d] !== 1'b0)
      $display("FAIL idle dut%0d: got busy=%b done=%b want 0/0", d, busy[d], done[d]);
    else n_pass++;
    n_checks++;
    if (sout[d] !== last_out[d]) $display("FAIL hold dut%0d: got %h want %h", d, sout[d], last_out[d]);
    else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (busy[d] !== 1'b0 || done[d] !== 1'b0 || sout[d] !== 32'h0)
          $display("FAIL reset dut%0d: got busy=%b done=%b out=%h want 0/0/0", d, busy[d], done[d], sout[d]);
        else n_pass++;
      end
    end
    rst = 1'b0; start[0] = 1'b0; start[1] = 1'b0;
    last_out[0] = 32'h0; last_out[1] = 32'h0;
    idle_check(0);
    idle_check(1);
  endtask

  task automatic test_step1();
    issue(0, 32'h00001998, 5'd25, 2'b00); expect_op(0, 32'h00001998, 5'd25, 2'b00, 1'b0); idle_check(0);
    issue(0, 32'h00001998, 5'd25, 2'b10); expect_op(0, 32'h00001998, 5'd25, 2'b10, 1'b0); idle_check(0);
  endtask

  task automatic test_step4();
    issue(1, 32'h80000000, 5'd4, 2'b11);  expect_op(1, 32'h80000000, 5'd4, 2'b11, 1'b0);  idle_check(1);
    issue(1, 32'h80000000, 5'd31, 2'b11); expect_op(1, 32'h80000000, 5'd31, 2'b11, 1'b0); idle_check(1);
  endtask

  task automatic test_ror();
    for (int d = 0; d < 2; d++) begin
      issue(d, 32'h00001998, 5'd4, 2'b01); expect_op(d, 32'h00001998, 5'd4, 2'b01, 1'b0); idle_check(d);
    end
  endtask

  task automatic test_amt_zero();
    logic [31:0] v;
    for (int d = 0; d < 2; d++) begin
      for (int op = 0; op < 4; op++) begin
        v = $urandom;
        issue(d, v, 5'd0, 2'(op)); expect_op(d, v, 5'd0, 2'(op), 1'b0); idle_check(d);
      end
    end
  endtask

  task automatic test_start_during_shift();
    issue(0, 32'hC0FFEE11, 5'd10, 2'b11); expect_op(0, 32'hC0FFEE11, 5'd10, 2'b11, 1'b1); idle_check(0);
    issue(1, 32'h12345678, 5'd13, 2'b00); expect_op(1, 32'h12345678, 5'd13, 2'b00, 1'b1); idle_check(1);
  endtask

  task automatic test_back_to_back();
    issue(0, 32'hF00F1234, 5'd3, 2'b10); expect_op(0, 32'hF00F1234, 5'd3, 2'b10, 1'b0);
    issue(0, 32'h8000F001, 5'd5, 2'b01); expect_op(0, 32'h8000F001, 5'd5, 2'b01, 1'b0);
    issue(0, 32'hA5A5A5A5, 5'd0, 2'b00); expect_op(0, 32'hA5A5A5A5, 5'd0, 2'b00, 1'b0);
    issue(0, 32'h00000003, 5'd2, 2'b00); expect_op(0, 32'h00000003, 5'd2, 2'b00, 1'b0);
    idle_check(0);
  endtask

  task automatic test_reset_midop();
    issue(0, 32'h00001998, 5'd25, 2'b00);
    for (int c = 1; c < 10; c++) begin
      n_checks++;
      if (busy[0] !== 1'b1) $display("FAIL midop busy cyc%0d: got %b want 1", c, busy[0]);
      else n_pass++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_out[0] = 32'h0; last_out[1] = 32'h0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || sout[0] !== 32'h0)
        $display("FAIL midop reset cyc%0d: got busy=%b done=%b out=%h want 0/0/0", c, busy[0], done[0], sout[0]);
      else n_pass++;
      @(negedge clk);
    end
    issue(0, 32'h0000ABCD, 5'd7, 2'b00); expect_op(0, 32'h0000ABCD, 5'd7, 2'b00, 1'b0); idle_check(0);
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [4:0]  a;
    logic [1:0]  o;
    int d;
    for (int i = 0; i < 40; i++) begin
      d = i % 2;
      v = $urandom;
      a = 5'($urandom);
      o = 2'($urandom);
      issue(d, v, a, o);
      expect_op(d, v, a, o, 1'b0);
      // Sometimes skip the idle cycle so that the next request from this
      // DUT is issued in its done cycle.
      if ($urandom_range(1, 0) == 1) idle_check(d);
      else begin
        v = $urandom; a = 5'($urandom); o = 2'($urandom);
        issue(d, v, a, o);
        expect_op(d, v, a, o, 1'b0);
        idle_check(d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b1; sin[d] = 32'hDEADBEEF; samt[d] = 5'd3; sop[d] = 2'b00;
      last_out[d] = 32'h0;
    end
    test_reset();
    test_step1();
    test_step4();
    test_ror();
    test_amt_zero();
    test_start_during_shift();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_shifter

`default_nettype wire
